// File: rtl/guarded_link_pkg.sv
// Types and defaults shared by both ends of the guarded serial link.
package guarded_link_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StGap} link_state_e;

  localparam int unsigned WIDTH_D  = 8;
  localparam int unsigned CTRL_W_D = 4;
  localparam int unsigned GAP_D    = 2;

  // Bits per frame: payload plus the optional parity bit.
  function automatic int unsigned NB_F(input int unsigned width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/guarded_serial_tx_if.sv
// Word-in / serial-out signal bundle of the guarded serial transmitter.
interface guarded_serial_tx_if
  import guarded_link_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_D,
  parameter int unsigned CTRL_W = CTRL_W_D
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [CTRL_W-1:0] in_ctl;
  logic              out_bit;
  logic [CTRL_W-1:0] out_ctl;
  logic              out_frame;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_ctl,
    input  in_ready, out_bit, out_ctl, out_frame, out_last
  );

  modport slave (
    input  in_valid, in_data, in_ctl,
    output in_ready, out_bit, out_ctl, out_frame, out_last
  );
endinterface

// File: rtl/guarded_serial_tx.sv
// Guarded serial transmitter: LSB-first, constant-time frames, tag held per frame.
// Define GUARDED_TX_PARITY_EN to append an even-parity bit to every frame.
module guarded_serial_tx
  import guarded_link_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_D,
  parameter int unsigned CTRL_W = CTRL_W_D,
  parameter int unsigned GAP    = GAP_D
) (
  input logic                clk,
  input logic                rst,
  guarded_serial_tx_if.slave link
);

`ifdef GUARDED_TX_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam int unsigned NB   = NB_F(WIDTH, ParityEn);
  localparam int unsigned IdxW = ($clog2(NB + 1) > 0) ? $clog2(NB + 1) : 1;
  localparam int unsigned GapW = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NB - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);

  link_state_e       state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [NB-1:0]     shreg_q, shreg_d;
  logic [CTRL_W-1:0] ctl_q, ctl_d;
  logic              frame_q, frame_d;
  logic              last_q, last_d;
  logic [NB-1:0]     load_word;

`ifdef GUARDED_TX_PARITY_EN
  assign load_word = {^link.in_data, link.in_data};
`else
  assign load_word = link.in_data;
`endif

  // Every path through StShift and StGap lasts a fixed number of cycles,
  // so no data or tag value can influence frame timing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    ctl_d   = ctl_q;
    unique case (state_q)
      StIdle: begin
        if (link.in_valid) begin
          state_d = StShift;
          idx_d   = '0;
          shreg_d = load_word;
          ctl_d   = link.in_ctl;
        end
      end
      StShift: begin
        if (idx_q == IdxLast) begin
          state_d = (GAP > 0) ? StGap : StIdle;
          idx_d   = '0;
          gap_d   = '0;
          shreg_d = '0;
          ctl_d   = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          shreg_d = shreg_q >> 1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    frame_d = (state_d == StShift);
    last_d  = (state_d == StShift) && (idx_d == IdxLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      ctl_q   <= '0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      ctl_q   <= ctl_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

  // The shift register is zero outside a frame, so out_bit needs no extra gating.
  assign link.out_bit   = shreg_q[0];
  assign link.out_ctl   = ctl_q;
  assign link.out_frame = frame_q;
  assign link.out_last  = last_q;
  assign link.in_ready  = (state_q == StIdle) && !rst;

endmodule

// File: tb/tb_guarded_serial_tx.sv
// Scoreboard bench for guarded_serial_tx (GAP=2 instance plus a GAP=0 instance).
module tb_guarded_serial_tx;
  import guarded_link_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned G  = 2;
`ifdef GUARDED_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int unsigned NB     = W + (PAR ? 1 : 0);
  localparam int unsigned PERIOD = 1 + NB + G;

  typedef struct packed {
    logic          b;
    logic          last;
    logic [CW-1:0] ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  guarded_serial_tx_if #(.WIDTH(W), .CTRL_W(CW)) bus ();
  guarded_serial_tx_if #(.WIDTH(W), .CTRL_W(CW)) bus0 ();

  guarded_serial_tx #(.WIDTH(W), .CTRL_W(CW), .GAP(G)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus.slave)
  );

  guarded_serial_tx #(.WIDTH(W), .CTRL_W(CW), .GAP(0)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .link (bus0.slave)
  );

  function automatic void push_exp(input logic [W-1:0] d, input logic [CW-1:0] c);
    exp_t e;
    for (int i = 0; i < int'(NB); i++) begin
      if (i < int'(W)) e.b = d[i];
      else e.b = ^d;
      e.last = (i == int'(NB) - 1);
      e.ctl  = c;
      sb.push_back(e);
    end
  endfunction

  task automatic wait_ready(input bit use0, output int n);
    n = 0;
    @(negedge clk);
    while (((use0 ? bus0.in_ready : bus.in_ready) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [CW+3:0] got;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = '1; bus.in_ctl = '1;
    repeat (2) @(negedge clk);
    got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
    checks++;
    if (got !== '0) $display("FAIL reset_outputs got %b required 0", got); else passes++;
    got = {bus0.in_ready, bus0.out_frame, bus0.out_last, bus0.out_ctl, bus0.out_bit};
    checks++;
    if (got !== '0) $display("FAIL reset_outputs_gap0 got %b required 0", got); else passes++;
    bus.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b required 1", bus.in_ready);
    else passes++;
    checks++;
    if (bus0.in_ready !== 1'b1) $display("FAIL reset_ready_gap0 got %b required 1", bus0.in_ready);
    else passes++;
  endtask

  task automatic test_single();
    exp_t e;
    logic [CW+3:0] got, expv;
    int n;
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_ctl = 4'hA;
    wait_ready(1'b0, n);
    checks++;
    if (n >= 40) $display("FAIL single_ready got timeout required ready"); else passes++;
    push_exp(8'hA5, 4'hA);
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctl = '0;
    for (int k = 1; k < int'(PERIOD); k++) begin
      @(negedge clk);
      if (k <= int'(NB)) begin
        e = sb.pop_front();
        expv = {1'b0, 1'b1, e.last, e.ctl, e.b};
      end else expv = '0;
      got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
      checks++;
      if (got !== expv) $display("FAIL single_k%0d got %b required %b", k, got, expv);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL single_ready_after got %b required 1", bus.in_ready);
    else passes++;
  endtask

  task automatic test_const_time();
    logic [W-1:0]  dv [2];
    logic [CW-1:0] cv [2];
    int            h [2];
    exp_t e;
    logic [CW+3:0] got, expv;
    int n;
    dv[0] = 8'h00; dv[1] = 8'hFF; cv[0] = 4'h0; cv[1] = 4'hF;
    for (int f = 0; f < 2; f++) begin
      bus.in_valid = 1'b1; bus.in_data = dv[f]; bus.in_ctl = cv[f];
      wait_ready(1'b0, n);
      checks++;
      if (n >= 40) $display("FAIL const_ready%0d got timeout required ready", f); else passes++;
      h[f] = cyc;
      push_exp(dv[f], cv[f]);
      @(posedge clk); #1;
      if (f == 1) bus.in_valid = 1'b0;
      for (int k = 1; k < int'(PERIOD); k++) begin
        @(negedge clk);
        if (k <= int'(NB)) begin
          e = sb.pop_front();
          expv = {1'b0, 1'b1, e.last, e.ctl, e.b};
        end else expv = '0;
        got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
        checks++;
        if (got !== expv) $display("FAIL const_f%0d_k%0d got %b required %b", f, k, got, expv);
        else passes++;
      end
    end
    checks++;
    if ((h[1] - h[0]) != int'(PERIOD))
      $display("FAIL const_period got %0d required %0d", h[1] - h[0], PERIOD);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL const_ready_after got %b required 1", bus.in_ready);
    else passes++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [CW+3:0] got, expv;
    int n;
    bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.in_ctl = 4'h6;
    wait_ready(1'b0, n);
    checks++;
    if (n >= 40) $display("FAIL bp_ready got timeout required ready"); else passes++;
    push_exp(8'h3C, 4'h6);
    for (int f = 0; f < 2; f++) begin
      @(posedge clk); #1;
      if (f == 1) bus.in_valid = 1'b0;
      for (int k = 1; k < int'(PERIOD); k++) begin
        @(negedge clk);
        if (k <= int'(NB)) begin
          e = sb.pop_front();
          expv = {1'b0, 1'b1, e.last, e.ctl, e.b};
        end else expv = '0;
        got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
        checks++;
        if (got !== expv) $display("FAIL bp_f%0d_k%0d got %b required %b", f, k, got, expv);
        else passes++;
        if (f == 0) begin
          bus.in_data = W'($urandom);
          bus.in_ctl  = CW'($urandom);
        end
      end
      if (f == 0) begin
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_rearm got %b required 1", bus.in_ready);
        else passes++;
        push_exp(bus.in_data, bus.in_ctl);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after got %b required 1", bus.in_ready);
    else passes++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [CW+3:0] got, expv;
    int n;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.in_ctl = 4'h9;
    wait_ready(1'b0, n);
    checks++;
    if (n >= 40) $display("FAIL rstmid_ready got timeout required ready"); else passes++;
    push_exp(8'h5A, 4'h9);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      expv = {1'b0, 1'b1, e.last, e.ctl, e.b};
      got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
      checks++;
      if (got !== expv) $display("FAIL rstmid_k%0d got %b required %b", k, got, expv);
      else passes++;
    end
    rst = 1'b1;
    #1;
    got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
    checks++;
    if (got !== '0) $display("FAIL rstmid_async got %b required 0", got); else passes++;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    expv = {1'b1, {(CW + 3){1'b0}}};
    for (int k = 1; k <= int'(PERIOD); k++) begin
      @(negedge clk);
      got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
      checks++;
      if (got !== expv) $display("FAIL rstmid_after_k%0d got %b required %b", k, got, expv);
      else passes++;
    end
  endtask

`ifdef GUARDED_TX_PARITY_EN
  task automatic test_parity();
    exp_t e;
    logic [CW+3:0] got, expv;
    int n;
    bus.in_valid = 1'b1; bus.in_data = 8'h07; bus.in_ctl = 4'h3;
    wait_ready(1'b0, n);
    checks++;
    if (n >= 40) $display("FAIL parity_ready got timeout required ready"); else passes++;
    push_exp(8'h07, 4'h3);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int k = 1; k < int'(PERIOD); k++) begin
      @(negedge clk);
      if (k <= int'(NB)) begin
        e = sb.pop_front();
        expv = {1'b0, 1'b1, e.last, e.ctl, e.b};
      end else expv = '0;
      got = {bus.in_ready, bus.out_frame, bus.out_last, bus.out_ctl, bus.out_bit};
      checks++;
      if (got !== expv) $display("FAIL parity_k%0d got %b required %b", k, got, expv);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL parity_ready_after got %b required 1", bus.in_ready);
    else passes++;
  endtask
`endif

  task automatic test_gap0();
    exp_t e;
    logic [CW+3:0] got, expv;
    int n;
    bus0.in_valid = 1'b1; bus0.in_data = 8'hC3; bus0.in_ctl = 4'h5;
    wait_ready(1'b1, n);
    checks++;
    if (n >= 40) $display("FAIL gap0_ready got timeout required ready"); else passes++;
    push_exp(8'hC3, 4'h5);
    for (int f = 0; f < 2; f++) begin
      @(posedge clk); #1;
      if (f == 0) begin
        bus0.in_data = 8'h96; bus0.in_ctl = 4'hC;
      end else bus0.in_valid = 1'b0;
      for (int k = 1; k <= int'(NB); k++) begin
        @(negedge clk);
        e = sb.pop_front();
        expv = {1'b0, 1'b1, e.last, e.ctl, e.b};
        got = {bus0.in_ready, bus0.out_frame, bus0.out_last, bus0.out_ctl, bus0.out_bit};
        checks++;
        if (got !== expv) $display("FAIL gap0_f%0d_k%0d got %b required %b", f, k, got, expv);
        else passes++;
      end
      @(negedge clk);
      expv = {1'b1, {(CW + 3){1'b0}}};
      got = {bus0.in_ready, bus0.out_frame, bus0.out_last, bus0.out_ctl, bus0.out_bit};
      checks++;
      if (got !== expv) $display("FAIL gap0_idle%0d got %b required %b", f, got, expv);
      else passes++;
      if (f == 0) push_exp(8'h96, 4'hC);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0; bus.in_data  = '0; bus.in_ctl  = '0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_ctl = '0;
    test_reset();
    test_single();
    test_const_time();
    test_backpressure();
    test_reset_mid();
`ifdef GUARDED_TX_PARITY_EN
    test_parity();
`endif
    test_gap0();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
